// File: rtl/ram_fifo_pkg.sv
// Shared types for the RAM-backed FIFO: occupancy update encoding.
package ram_fifo_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

  // A simultaneous push and pop leaves occupancy unchanged.
  function automatic cnt_op_e cnt_op(input logic push, input logic pop);
    if (push && !pop) return CNT_INC;
    if (pop && !push) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/ram_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read address, asynchronous
// read of the registered address, so a word written at an edge is readable right after it.
module ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] raddr_reg;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    raddr_reg <= raddr;
  end

  assign dout = mem[raddr_reg];

endmodule

// File: rtl/ram_fifo.sv
// First-word-fall-through FIFO with valid/ready streams, storing entries in the ram block.
// Flags come only from the registered occupancy count.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 4,
  parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop, we;
  logic [ADDR_WIDTH-1:0] raddr;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CNT_W'(AFULL_LEVEL));
  assign wr_ready    = !full;
  assign rd_valid    = !empty;
  assign count       = count_q;

  assign push = wr_valid & wr_ready;
  assign pop  = rd_valid & rd_ready;
  assign we   = push & !flush;

  // Next head address: the RAM registers it so dout tracks mem[rd_ptr] after the edge.
  assign raddr = flush ? '0 : rd_ptr_q + ADDR_WIDTH'(pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop);
    count_d  = count_q;
    case (cnt_op(push, pop))
      CNT_INC: count_d = count_q + 1'b1;
      CNT_DEC: count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr_q),
    .din  (wr_data),
    .raddr(raddr),
    .dout (rd_data)
  );

endmodule

// File: tb/tb_ram_fifo.sv
// Scoreboard bench for ram_fifo with a depth-4 configuration and directed vectors.
module tb_ram_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_data = '0;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic [3:0] rd_data;
  logic [2:0] count;
  logic       full, empty, almost_full;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  ram_fifo #(
    .ADDR_WIDTH (2),
    .DATA_WIDTH (4),
    .AFULL_LEVEL(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the coming edge, so the head must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready && !flush) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %0h, expected no data (t=%0t)", rd_data, $time);
      end else begin
        chk("rd_data", {4'h0, rd_data}, {4'h0, sb.pop_front()});
      end
    end
  end

  // One clock cycle of stimulus; called just after a rising edge.
  task automatic cyc(input logic wv, input logic [3:0] wd, input logic rr, input logic fl);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    @(negedge clk);
    if (fl) sb.delete();
    else if (wv && wr_ready) sb.push_back(wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {5'h0, count}, 8'd0);
    chk("rst_empty", {7'h0, empty}, 8'd1);
    chk("rst_full", {7'h0, full}, 8'd0);
    chk("rst_wr_ready", {7'h0, wr_ready}, 8'd1);
    chk("rst_rd_valid", {7'h0, rd_valid}, 8'd0);
    chk("rst_afull", {7'h0, almost_full}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, one-cycle latency, then pop
    cyc(1'b1, 4'hA, 1'b0, 1'b0);
    chk("t1_rd_valid", {7'h0, rd_valid}, 8'd1);
    chk("t1_rd_data", {4'h0, rd_data}, 8'h0A);
    chk("t1_count", {5'h0, count}, 8'd1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("t1_empty", {7'h0, empty}, 8'd1);

    // Fill to full; a fifth write is refused
    cyc(1'b1, 4'h1, 1'b0, 1'b0);
    chk("t2_afull_1", {7'h0, almost_full}, 8'd0);
    cyc(1'b1, 4'h2, 1'b0, 1'b0);
    chk("t2_afull_2", {7'h0, almost_full}, 8'd1);
    chk("t2_full_2", {7'h0, full}, 8'd0);
    cyc(1'b1, 4'h3, 1'b0, 1'b0);
    chk("t2_count_3", {5'h0, count}, 8'd3);
    cyc(1'b1, 4'h4, 1'b0, 1'b0);
    chk("t2_full_4", {7'h0, full}, 8'd1);
    chk("t2_wr_ready_4", {7'h0, wr_ready}, 8'd0);
    cyc(1'b1, 4'h5, 1'b0, 1'b0);
    chk("t2_count_5th", {5'h0, count}, 8'd4);
    chk("t2_head", {4'h0, rd_data}, 8'h01);

    // Drain 1..4, refill with 5..8 across the pointer wrap, drain again
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("t3_empty_a", {7'h0, empty}, 8'd1);
    for (int i = 5; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
    chk("t3_full", {7'h0, full}, 8'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("t3_empty_b", {7'h0, empty}, 8'd1);

    // Sustained push+pop streaming from empty
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 4'(i), 1'b1, 1'b0);
      chk("t4_count", {5'h0, count}, 8'd1);
    end
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("t4_empty", {7'h0, empty}, 8'd1);
    chk("t4_sb_drained", 8'(sb.size()), 8'd0);

    // Flush wins over a concurrent push and pop
    cyc(1'b1, 4'hB, 1'b0, 1'b0);
    cyc(1'b1, 4'hC, 1'b0, 1'b0);
    cyc(1'b1, 4'hD, 1'b0, 1'b0);
    chk("t5_count_pre", {5'h0, count}, 8'd3);
    cyc(1'b1, 4'hE, 1'b1, 1'b1);
    chk("t5_count", {5'h0, count}, 8'd0);
    chk("t5_empty", {7'h0, empty}, 8'd1);
    idle();
    chk("t5_still_empty", {7'h0, rd_valid}, 8'd0);
    cyc(1'b1, 4'h9, 1'b0, 1'b0);
    chk("t5_new_head", {4'h0, rd_data}, 8'h09);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-burst
    cyc(1'b1, 4'h1, 1'b0, 1'b0);
    cyc(1'b1, 4'h2, 1'b0, 1'b0);
    cyc(1'b1, 4'h3, 1'b0, 1'b0);
    chk("t6_count_pre", {5'h0, count}, 8'd3);
    wr_valid = 1'b1;
    wr_data  = 4'h4;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_count", {5'h0, count}, 8'd0);
    chk("t6_rd_valid", {7'h0, rd_valid}, 8'd0);
    chk("t6_wr_ready", {7'h0, wr_ready}, 8'd1);
    sb.delete();
    wr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_empty_after", {7'h0, empty}, 8'd1);
    cyc(1'b1, 4'h7, 1'b0, 1'b0);
    chk("t6_rd_valid_7", {7'h0, rd_valid}, 8'd1);
    chk("t6_rd_data_7", {4'h0, rd_data}, 8'h07);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    chk("end_sb_empty", 8'(sb.size()), 8'd0);
    chk("end_empty", {7'h0, empty}, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
